scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer_if.sv | 33 +++
 rtl/scan_sequencer.sv | 171 +++++++++++++++++
 tb/tb_scan_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_sequencer_if.sv
// Bundle of host request/status and line-counter control signals for scan_sequencer.
// The slave side is the sequencer; the master side is the host plus the line counter.
interface scan_sequencer_if;
  logic        sq_start;
  logic        sq_abort;
  logic [31:0] sq_line_len;
  logic [15:0] sq_num_lines;
  logic        cr_cof;
  logic [31:0] cr_dout;
  logic        cr_en;
  logic        cr_halt;
  logic        cr_rst;
  logic        cr_loadmax;
  logic [31:0] d_max;
  logic [15:0] sq_line_idx;
  logic [31:0] sq_line_cnt;
  logic        sq_line_stb;
  logic        sq_busy;
  logic        sq_done;
  logic        sq_err;

  modport master (
    output sq_start, sq_abort, sq_line_len, sq_num_lines, cr_cof, cr_dout,
    input  cr_en, cr_halt, cr_rst, cr_loadmax, d_max,
    input  sq_line_idx, sq_line_cnt, sq_line_stb, sq_busy, sq_done, sq_err
  );

  modport slave (
    input  sq_start, sq_abort, sq_line_len, sq_num_lines, cr_cof, cr_dout,
    output cr_en, cr_halt, cr_rst, cr_loadmax, d_max,
    output sq_line_idx, sq_line_cnt, sq_line_stb, sq_busy, sq_done, sq_err
  );
endinterface

// File: rtl/scan_sequencer.sv
// Multi-line scan sequencer: drives an external line counter through load/arm/run/stop
// for each line, inserts a dwell between lines, and guards every line with a timeout.
//
// state | meaning
// IDLE  | waiting for start; inputs latched on start
// LOAD  | reset line counter and load its limit
// ARM   | enable line counter, clear timeout
// RUN   | wait for counter limit flag or timeout
// STOP  | halt line counter, pick next step
// DWELL | idle gap between lines
// FIN   | one-cycle scan-complete pulse
module scan_sequencer #(
  parameter int unsigned DWELL_CYC   = 4,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input logic              sq_clk_i,
  input logic              sq_rst_i,
  scan_sequencer_if.slave  sq_if
);

  localparam int unsigned    TW         = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]  TMO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]     DWELL_LAST = 8'(DWELL_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_RUN,
    S_STOP,
    S_DWELL,
    S_FIN
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   len_q, len_d;
  logic [15:0]   lines_q, lines_d;
  logic [15:0]   idx_q, idx_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          stb_q, stb_d;
  logic          err_q, err_d;
  logic          kill_q, kill_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    dwell_q, dwell_d;

  always_ff @(posedge sq_clk_i) begin
    if (sq_rst_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      lines_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      stb_q   <= 1'b0;
      err_q   <= 1'b0;
      kill_q  <= 1'b0;
      tmo_q   <= '0;
      dwell_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      lines_q <= lines_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
      kill_q  <= kill_d;
      tmo_q   <= tmo_d;
      dwell_q <= dwell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lines_d = lines_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    stb_d   = 1'b0;
    err_d   = err_q;
    kill_d  = kill_q;
    tmo_d   = tmo_q;
    dwell_d = dwell_q;

    case (state_q)
      S_IDLE: begin
        if (sq_if.sq_start) begin
          len_d   = sq_if.sq_line_len;
          lines_d = sq_if.sq_num_lines;
          err_d   = 1'b0;
          idx_d   = '0;
          kill_d  = 1'b0;
          state_d = (sq_if.sq_num_lines == 16'd0) ? S_FIN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (sq_if.sq_abort) begin
          kill_d  = 1'b1;
          state_d = S_STOP;
        end else begin
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        tmo_d = '0;
        if (sq_if.sq_abort) begin
          kill_d  = 1'b1;
          state_d = S_STOP;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Abort beats a same-cycle limit flag, which in turn beats the timeout.
        if (sq_if.sq_abort) begin
          kill_d  = 1'b1;
          state_d = S_STOP;
        end else if (sq_if.cr_cof) begin
          cnt_d   = sq_if.cr_dout;
          stb_d   = 1'b1;
          state_d = S_STOP;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          kill_d  = 1'b1;
          state_d = S_STOP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_STOP: begin
        if (kill_q) begin
          state_d = S_IDLE;
        end else if (idx_q == lines_q - 16'd1) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + 16'd1;
          dwell_d = DWELL_LAST;
          state_d = S_DWELL;
        end
      end
      S_DWELL: begin
        if (sq_if.sq_abort) begin
          kill_d  = 1'b1;
          state_d = S_STOP;
        end else if (dwell_q == 8'd0) begin
          state_d = S_LOAD;
        end else begin
          dwell_d = dwell_q - 8'd1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sq_if.cr_rst      = (state_q == S_LOAD);
  assign sq_if.cr_loadmax  = (state_q == S_LOAD);
  assign sq_if.cr_en       = (state_q == S_ARM);
  assign sq_if.cr_halt     = (state_q == S_STOP);
  assign sq_if.sq_done     = (state_q == S_FIN);
  assign sq_if.sq_busy     = (state_q != S_IDLE);
  assign sq_if.d_max       = len_q;
  assign sq_if.sq_line_idx = idx_q;
  assign sq_if.sq_line_cnt = cnt_q;
  assign sq_if.sq_line_stb = stb_q;
  assign sq_if.sq_err      = err_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer with a behavioural line-counter model.
module tb_scan_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scan_sequencer_if itf ();

  scan_sequencer #(
    .DWELL_CYC   (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .sq_clk_i (clk),
    .sq_rst_i (rst),
    .sq_if    (itf)
  );

  // Line counter model: counts from 0 up to the loaded limit once enabled.
  logic [31:0] m_cnt = '0;
  logic [31:0] m_max = '0;
  logic        m_run = 1'b0;
  logic        cof_tie0 = 1'b0;

  always @(posedge clk) begin
    if (rst || itf.cr_halt || itf.cr_rst) m_run <= 1'b0;
    else if (itf.cr_en)                   m_run <= 1'b1;
    if (itf.cr_rst)                       m_cnt <= '0;
    else if (m_run && m_cnt != m_max)     m_cnt <= m_cnt + 32'd1;
    if (itf.cr_loadmax)                   m_max <= itf.d_max;
  end

  assign itf.cr_cof  = !cof_tie0 && m_run && (m_cnt == m_max);
  assign itf.cr_dout = m_cnt;

  int checks   = 0;
  int failures = 0;
  int stb_n, done_n, en_n, crrst_n, halt_n, run_n;
  bit run_f;
  logic [31:0] stb_cnt[$];
  logic [15:0] stb_idx[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    stb_n = 0; done_n = 0; en_n = 0; crrst_n = 0; halt_n = 0; run_n = 0;
    run_f = 1'b0;
    stb_cnt.delete();
    stb_idx.delete();
  endtask

  task automatic cyc();
    @(negedge clk);
    if (itf.sq_line_stb) begin
      stb_n++;
      stb_cnt.push_back(itf.sq_line_cnt);
      stb_idx.push_back(itf.sq_line_idx);
    end
    if (itf.sq_done) done_n++;
    if (itf.cr_en)   en_n++;
    if (itf.cr_rst)  crrst_n++;
    if (itf.cr_halt) begin
      halt_n++;
      run_f = 1'b0;
    end else if (run_f) begin
      run_n++;
    end
    if (itf.cr_en) run_f = 1'b1;
  endtask

  task automatic start_scan(input logic [31:0] len, input logic [15:0] lines);
    itf.sq_line_len  = len;
    itf.sq_num_lines = lines;
    itf.sq_start     = 1'b1;
    cyc();
    itf.sq_start     = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!itf.sq_busy) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_stb(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && stb_n < n; i++) cyc();
    chk(tag, 32'(stb_n), 32'(n));
  endtask

  initial begin
    bit seen;
    itf.sq_start     = 1'b0;
    itf.sq_abort     = 1'b0;
    itf.sq_line_len  = '0;
    itf.sq_num_lines = '0;
    clr_mon();

    // Reset state
    repeat (2) cyc();
    chk("rst_busy", 32'(itf.sq_busy), 32'd0);
    chk("rst_dmax", itf.d_max, 32'd0);
    chk("rst_idx", 32'(itf.sq_line_idx), 32'd0);
    chk("rst_cnt", itf.sq_line_cnt, 32'd0);
    chk("rst_flags", 32'({itf.sq_err, itf.sq_done, itf.sq_line_stb, itf.cr_en,
                          itf.cr_halt, itf.cr_rst, itf.cr_loadmax}), 32'd0);
    rst = 1'b0;
    cyc();

    // Normal 3-line scan; late input changes and a busy START must be ignored
    clr_mon();
    start_scan(32'd5, 16'd3);
    itf.sq_line_len  = 32'd9;
    itf.sq_num_lines = 16'd7;
    chk("n_load", 32'({itf.cr_rst, itf.cr_loadmax}), 32'd3);
    chk("n_dmax", itf.d_max, 32'd5);
    cyc();
    itf.sq_start = 1'b1;
    cyc();
    itf.sq_start = 1'b0;
    wait_idle("n_idle", 200);
    chk("n_stbs", 32'(stb_n), 32'd3);
    foreach (stb_cnt[i]) begin
      chk("n_line_cnt", stb_cnt[i], 32'd5);
      chk("n_line_idx", 32'(stb_idx[i]), 32'(i));
    end
    chk("n_done", 32'(done_n), 32'd1);
    chk("n_run_cyc", 32'(run_n), 32'd18);
    chk("n_idx_end", 32'(itf.sq_line_idx), 32'd2);
    chk("n_err", 32'(itf.sq_err), 32'd0);

    // Zero lines: straight to FIN, no counter activity
    clr_mon();
    start_scan(32'd7, 16'd0);
    chk("z_done", 32'(itf.sq_done), 32'd1);
    chk("z_busy", 32'(itf.sq_busy), 32'd1);
    cyc();
    chk("z_done_off", 32'(itf.sq_done), 32'd0);
    chk("z_idle", 32'(itf.sq_busy), 32'd0);
    chk("z_cr_activity", 32'(en_n + crrst_n), 32'd0);

    // Timeout with the limit flag held low
    clr_mon();
    cof_tie0 = 1'b1;
    start_scan(32'd5, 16'd2);
    wait_idle("t_idle", 100);
    chk("t_err", 32'(itf.sq_err), 32'd1);
    chk("t_halt", 32'(halt_n), 32'd1);
    chk("t_run_cyc", 32'(run_n), 32'd16);
    chk("t_done", 32'(done_n), 32'd0);
    chk("t_stb", 32'(stb_n), 32'd0);
    cof_tie0 = 1'b0;
    clr_mon();
    start_scan(32'd2, 16'd1);
    chk("t_err_clr", 32'(itf.sq_err), 32'd0);
    wait_idle("t2_idle", 100);
    chk("t2_done", 32'(done_n), 32'd1);
    chk("t2_cnt", itf.sq_line_cnt, 32'd2);

    // Abort during the dwell after line 0
    clr_mon();
    start_scan(32'd5, 16'd4);
    wait_stb("a_stb", 1, 100);
    cyc();
    chk("a_dwell_idx", 32'(itf.sq_line_idx), 32'd1);
    itf.sq_abort = 1'b1;
    cyc();
    itf.sq_abort = 1'b0;
    chk("a_halt", 32'(itf.cr_halt), 32'd1);
    cyc();
    chk("a_idle", 32'(itf.sq_busy), 32'd0);
    chk("a_idx", 32'(itf.sq_line_idx), 32'd1);
    chk("a_done", 32'(done_n), 32'd0);
    chk("a_stbn", 32'(stb_n), 32'd1);

    // Reset during RUN of line 2, then reset priority over START/ABORT
    clr_mon();
    start_scan(32'd5, 16'd3);
    wait_stb("r_stb", 2, 200);
    for (int i = 0; i < 50 && en_n < 3; i++) cyc();
    chk("r_arm", 32'(en_n), 32'd3);
    cyc();
    chk("r_run_idx", 32'(itf.sq_line_idx), 32'd2);
    rst = 1'b1;
    cyc();
    chk("r_busy", 32'(itf.sq_busy), 32'd0);
    chk("r_cnt", itf.sq_line_cnt, 32'd0);
    chk("r_idx", 32'(itf.sq_line_idx), 32'd0);
    chk("r_dmax", itf.d_max, 32'd0);
    chk("r_flags", 32'({itf.sq_err, itf.sq_done, itf.sq_line_stb, itf.cr_en,
                        itf.cr_halt, itf.cr_rst, itf.cr_loadmax}), 32'd0);
    itf.sq_start = 1'b1;
    itf.sq_abort = 1'b1;
    itf.sq_line_len  = 32'd5;
    itf.sq_num_lines = 16'd1;
    cyc();
    chk("r_prio", 32'(itf.sq_busy), 32'd0);
    itf.sq_start = 1'b0;
    itf.sq_abort = 1'b0;
    rst = 1'b0;
    cyc();

    // Limit flag and timeout in the same RUN cycle; abort in STOP ignored
    clr_mon();
    start_scan(32'd15, 16'd1);
    wait_stb("c_stb", 1, 100);
    itf.sq_abort = 1'b1;
    cyc();
    itf.sq_abort = 1'b0;
    chk("c_fin", 32'(itf.sq_done), 32'd1);
    chk("c_err", 32'(itf.sq_err), 32'd0);
    wait_idle("c_idle", 20);
    chk("c_cnt", itf.sq_line_cnt, 32'd15);
    chk("c_run_cyc", 32'(run_n), 32'd16);
    chk("c_donen", 32'(done_n), 32'd1);

    // Abort coincident with the limit flag
    clr_mon();
    start_scan(32'd3, 16'd2);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (itf.cr_cof) begin
        seen = 1'b1;
        break;
      end
    end
    chk("x_cof_seen", 32'(seen), 32'd1);
    itf.sq_abort = 1'b1;
    cyc();
    itf.sq_abort = 1'b0;
    chk("x_halt", 32'(itf.cr_halt), 32'd1);
    chk("x_stb", 32'(itf.sq_line_stb), 32'd0);
    cyc();
    chk("x_idle", 32'(itf.sq_busy), 32'd0);
    chk("x_cnt", itf.sq_line_cnt, 32'd15);
    chk("x_stbn", 32'(stb_n), 32'd0);
    chk("x_done", 32'(done_n), 32'd0);

    // Zero-length line completes on the first limit flag
    clr_mon();
    start_scan(32'd0, 16'd1);
    wait_idle("l0_idle", 50);
    chk("l0_cnt", itf.sq_line_cnt, 32'd0);
    chk("l0_stbn", 32'(stb_n), 32'd1);
    chk("l0_run_cyc", 32'(run_n), 32'd1);
    chk("l0_done", 32'(done_n), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
